// File: rtl/dsp_mac_pkg.sv
// Shared types and width/saturation helpers for the dsp_mac_pipe MAC engine.
package dsp_mac_pkg;

   typedef struct packed {
      logic first;
      logic last;
      logic valid;
   } mac_beat_t;

   function automatic int prod_width(input int bw);
      return 2 * bw;
   endfunction

   function automatic int sum_width(input int bw, input int lanes);
      return 2 * bw + $clog2(lanes);
   endfunction

   function automatic longint sat_max(input int acc_w);
      return (longint'(1) <<< (acc_w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int acc_w);
      return -(longint'(1) <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One signed BIT_WIDTH x BIT_WIDTH multiplier lane with PIPE_STAGES registers,
// a shared stall enable and zero-skip operand gating.
module dsp_mac_lane
   import dsp_mac_pkg::*;
#(
   parameter int BIT_WIDTH   = 8,
   parameter int PIPE_STAGES = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  i_en,
   input  logic                                  i_valid,
   input  logic signed [BIT_WIDTH-1:0]           i_a,
   input  logic signed [BIT_WIDTH-1:0]           i_b,
   output logic signed [prod_width(BIT_WIDTH)-1:0] o_prod
);

   localparam int PW = prod_width(BIT_WIDTH);

   logic                    w_zero_in;
   logic [PIPE_STAGES-1:0]  r_zero;
   logic signed [PW-1:0]    r_prod [PIPE_STAGES];

   assign w_zero_in = !i_valid || (i_a == '0) || (i_b == '0);

   // A zero flag travels with each stage; data registers only load for non-zero products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= '1;
         for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            r_prod[s] <= '0;
         end
      end else if (i_en) begin
         r_zero[0] <= w_zero_in;
         if (!w_zero_in) begin
            r_prod[0] <= PW'(i_a) * PW'(i_b);
         end
         for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            r_zero[s] <= r_zero[s-1];
            if (!r_zero[s-1]) begin
               r_prod[s] <= r_prod[s-1];
            end
         end
      end
   end

   assign o_prod = r_zero[PIPE_STAGES-1] ? '0 : r_prod[PIPE_STAGES-1];

endmodule

// File: rtl/dsp_mac_pipe.sv
// Multi-lane signed MAC engine: per-packet accumulation of lane-product sums.
// Optional DSP_MAC_SAT_EN enables clamped accumulation with a sticky out_sat flag.
module dsp_mac_pipe
   import dsp_mac_pkg::*;
#(
   parameter int BIT_WIDTH   = 8,
   parameter int LANES       = 4,
   parameter int PIPE_STAGES = 2,
   parameter int ACC_WIDTH   = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic [LANES*BIT_WIDTH-1:0]   in_a,
   input  logic [LANES*BIT_WIDTH-1:0]   in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_WIDTH-1:0]         out_acc,
   output logic [CNT_WIDTH-1:0]         out_beats,
   output logic                         out_sat
);

   localparam int PW = prod_width(BIT_WIDTH);
   localparam int SW = sum_width(BIT_WIDTH, LANES);

   logic                          w_en;
   mac_beat_t                     r_s0_meta;
   logic [LANES*BIT_WIDTH-1:0]    r_s0_a;
   logic [LANES*BIT_WIDTH-1:0]    r_s0_b;
   mac_beat_t                     r_meta [PIPE_STAGES];
   logic signed [PW-1:0]          w_prod [LANES];
   logic signed [SW-1:0]          w_lane_sum;
   logic signed [SW-1:0]          r_sum;
   mac_beat_t                     r_sum_meta;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [ACC_WIDTH-1:0]   w_sum_ext;
   logic signed [ACC_WIDTH-1:0]   w_acc_base;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;
   logic [CNT_WIDTH-1:0]          r_cnt;
   logic [CNT_WIDTH-1:0]          w_cnt_base;
   logic [CNT_WIDTH-1:0]          w_cnt_next;
   logic                          r_out_valid;
   logic [ACC_WIDTH-1:0]          r_out_acc;
   logic [CNT_WIDTH-1:0]          r_out_beats;

   // Whole pipeline freezes only while a result is waiting on the consumer.
   assign w_en      = !(r_out_valid && !out_ready);
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;
   assign out_acc   = r_out_acc;
   assign out_beats = r_out_beats;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_meta <= '0;
         r_s0_a    <= '0;
         r_s0_b    <= '0;
         for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            r_meta[s] <= '0;
         end
      end else if (w_en) begin
         r_s0_meta <= '{first: in_first, last: in_last, valid: in_valid};
         if (in_valid) begin
            r_s0_a <= in_a;
            r_s0_b <= in_b;
         end
         r_meta[0] <= r_s0_meta;
         for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            r_meta[s] <= r_meta[s-1];
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dsp_mac_lane #(
         .BIT_WIDTH   (BIT_WIDTH),
         .PIPE_STAGES (PIPE_STAGES)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_en),
         .i_valid (r_s0_meta.valid),
         .i_a     (r_s0_a[l*BIT_WIDTH +: BIT_WIDTH]),
         .i_b     (r_s0_b[l*BIT_WIDTH +: BIT_WIDTH]),
         .o_prod  (w_prod[l])
      );
   end

   always_comb begin
      w_lane_sum = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_lane_sum = w_lane_sum + SW'(w_prod[l]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum      <= '0;
         r_sum_meta <= '0;
      end else if (w_en) begin
         r_sum      <= w_lane_sum;
         r_sum_meta <= r_meta[PIPE_STAGES-1];
      end
   end

   always_comb begin
      w_sum_ext  = ACC_WIDTH'(r_sum);
      w_acc_base = r_sum_meta.first ? '0 : r_acc;
      w_cnt_base = r_sum_meta.first ? '0 : r_cnt;
      w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_WIDTH'(1);
   end

`ifdef DSP_MAC_SAT_EN
   localparam logic signed [ACC_WIDTH:0] LP_SAT_MAX = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH:0] LP_SAT_MIN = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] w_wide;
   logic                      w_clamp;
   logic                      w_sat_next;
   logic                      r_sat_sticky;
   logic                      r_out_sat;

   // One guard bit is enough: a clamped acc plus one lane sum cannot exceed ACC_WIDTH+1 bits.
   always_comb begin
      w_wide     = (ACC_WIDTH+1)'(w_acc_base) + (ACC_WIDTH+1)'(w_sum_ext);
      w_clamp    = 1'b0;
      w_acc_next = w_wide[ACC_WIDTH-1:0];
      if (w_wide > LP_SAT_MAX) begin
         w_acc_next = LP_SAT_MAX[ACC_WIDTH-1:0];
         w_clamp    = 1'b1;
      end else if (w_wide < LP_SAT_MIN) begin
         w_acc_next = LP_SAT_MIN[ACC_WIDTH-1:0];
         w_clamp    = 1'b1;
      end
      w_sat_next = (!r_sum_meta.first && r_sat_sticky) || w_clamp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_sticky <= 1'b0;
         r_out_sat    <= 1'b0;
      end else if (w_en && r_sum_meta.valid) begin
         if (r_sum_meta.last) begin
            r_out_sat    <= w_sat_next;
            r_sat_sticky <= 1'b0;
         end else begin
            r_sat_sticky <= w_sat_next;
         end
      end
   end

   assign out_sat = r_out_sat;
`else
   assign w_acc_next = w_acc_base + w_sum_ext;
   assign out_sat    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_beats <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_en && r_sum_meta.valid) begin
            if (r_sum_meta.last) begin
               r_out_acc   <= w_acc_next;
               r_out_beats <= w_cnt_next;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= w_cnt_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe (ACC_WIDTH=18, CNT_WIDTH=3) with a result scoreboard.
module tb_dsp_mac_pipe;

   localparam int  ACCW = 18;
   localparam int  CNTW = 3;
   localparam longint MAXV = 131071;
   localparam longint MINV = -131072;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_first;
   logic             in_last;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             out_valid;
   logic             out_ready;
   logic [ACCW-1:0]  out_acc;
   logic [CNTW-1:0]  out_beats;
   logic             out_sat;

   always #5 clk = ~clk;

   dsp_mac_pipe #(
      .BIT_WIDTH   (8),
      .LANES       (4),
      .PIPE_STAGES (2),
      .ACC_WIDTH   (ACCW),
      .CNT_WIDTH   (CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_beats (out_beats),
      .out_sat   (out_sat)
   );

   typedef struct {
      logic [ACCW-1:0] acc;
      logic [CNTW-1:0] beats;
      logic            sat;
   } exp_t;

   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   int     pushed = 0;
   int     popped = 0;
   longint m_acc;
   int     m_cnt;
   bit     m_sat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
      return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic longint lane_sum(input logic [31:0] a, input logic [31:0] b);
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
         logic signed [7:0] x;
         logic signed [7:0] y;
         x = a[i*8 +: 8];
         y = b[i*8 +: 8];
         s += longint'(x) * longint'(y);
      end
      return s;
   endfunction

   task automatic model_reset();
      m_acc = 0;
      m_cnt = 0;
      m_sat = 0;
   endtask

   task automatic model_accept(input bit f, input bit l, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [ACCW-1:0] t;
      if (f) model_reset();
      m_acc += lane_sum(a, b);
`ifdef DSP_MAC_SAT_EN
      if (m_acc > MAXV) begin
         m_acc = MAXV;
         m_sat = 1;
      end else if (m_acc < MINV) begin
         m_acc = MINV;
         m_sat = 1;
      end
`else
      t = m_acc[ACCW-1:0];
      m_acc = longint'(t);
`endif
      m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
      if (l) begin
         e.acc   = m_acc[ACCW-1:0];
         e.beats = CNTW'(m_cnt);
         e.sat   = m_sat;
         q.push_back(e);
         pushed++;
         model_reset();
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input bit f, input bit l, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      in_a     = a;
      in_b     = b;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(f, l, a, b);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 for 200 cycles, expected acceptance");
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
      @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask

   logic            prev_stall = 1'b0;
   logic [ACCW-1:0] prev_acc   = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            if (prev_stall) chk("stall_acc_stable", out_acc, prev_acc);
            prev_stall <= 1'b1;
            prev_acc   <= out_acc;
         end else begin
            prev_stall <= 1'b0;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_output: observed acc=%0d, expected no result", out_acc);
            end else begin
               chk("out_acc", out_acc, q[0].acc);
               chk("out_beats", out_beats, q[0].beats);
               chk("out_sat", out_sat, q[0].sat);
               void'(q.pop_front());
               popped++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          len;
      int          dropped;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      model_reset();

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc", out_acc, 0);
      chk("rst_out_beats", out_beats, 0);
      chk("rst_out_sat", out_sat, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", in_ready, 1);
      @(posedge clk);
      #1;

      // Single beat: 16129 - 16256 - 1 + 0 = -128, valid after edge k+4.
      send(1, 1, pack4(127, -128, 1, 0), pack4(127, 127, -1, 5));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("latency_pre", out_valid, 0);
      @(negedge clk);
      chk("latency_valid", out_valid, 1);
      chk("single_acc", out_acc, 32'h3FF80);
      chk("single_beats", out_beats, 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) send(i == 0, i == 2, pack4(64, 64, 64, 64), pack4(64, 64, 64, 64));
      send(0, 1, pack4(2, 3, 4, 5), pack4(1, 1, 1, 1));
      send(1, 0, pack4(10, 10, 10, 10), pack4(10, 10, 10, 10));
      send(1, 0, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3));
      send(0, 1, pack4(20, 20, 20, 20), pack4(20, 20, 20, 20));
      for (int i = 0; i < 9; i++) send(i == 0, i == 8, pack4(1, 0, 0, 0), pack4(1, 1, 1, 1));
      for (int i = 0; i < 5; i++) send(i == 0, i == 4, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128));
      for (int p = 0; p < 6; p++) begin
         len = $urandom_range(1, 3);
         for (int i = 0; i < len; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(i == 0, i == len - 1, ra, rb);
         end
      end
      wait_drain();

      fork
         begin
            out_ready = 1'b0;
            repeat (14) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int p = 0; p < 4; p++) begin
               send(1, 0, pack4(p + 1, 2, 3, 4), pack4(5, p + 6, 7, 8));
               send(0, 1, pack4(-(p + 1), 9, 0, 11), pack4(12, 13, 14, -(p + 15)));
            end
         end
      join
      wait_drain();

      send(1, 0, pack4(7, 7, 7, 7), pack4(9, 9, 9, 9));
      send(0, 1, pack4(5, 5, 5, 5), pack4(9, 9, 9, 9));
      #2 rst_n = 1'b0;
      dropped = q.size();
      q.delete();
      pushed -= dropped;
      model_reset();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_acc", out_acc, 0);
      chk("midrst_out_beats", out_beats, 0);
      chk("midrst_out_sat", out_sat, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", in_ready, 1);
      repeat (8) @(negedge clk);
      chk("no_stale_result", out_valid, 0);
      @(posedge clk);
      #1;
      send(1, 1, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
      wait_drain();

      chk("queue_empty", q.size(), 0);
      chk("packets_delivered", popped, pushed);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
